// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the parametrised UART receiver.
//               Defines the receiver state encoding, the parity-mode encodings
//               and a helper that turns the running XOR of a frame into a
//               parity-error flag.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // xor_all is the XOR of every data bit and the received parity bit.
    // Odd parity expects that XOR to be 1, even parity expects 0.
    function automatic logic parity_error(input int mode, input logic xor_all);
        logic err;
        err = 1'b0;
        case (mode)
            PAR_ODD:  err = ~xor_all;
            PAR_EVEN: err = xor_all;
            default:  err = 1'b0;
        endcase
        return err;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sampler
// Description : Front end of the UART receiver. Brings the asynchronous RX pin
//               into the clock domain through two flops, detects the falling
//               edge that marks a start bit and produces the bit decision used
//               by the receiver FSM.
//               Build option UART_RX_MAJORITY_EN: bit_val is the 2-of-3
//               majority of rx_s over three consecutive cycles; otherwise
//               bit_val is rx_s itself.
// Ports       : clk      - system clock
//               rst_n    - asynchronous active-low reset
//               in_data  - raw RX pin, idle high
//               rx_s     - synchronised RX line
//               rx_fall  - rx_s went 1 -> 0 on this cycle
//               bit_val  - bit decision (single sample or majority)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sampler (
    input  logic clk,
    input  logic rst_n,
    input  logic in_data,
    output logic rx_s,
    output logic rx_fall,
    output logic bit_val
);

    logic r_sync1;
    logic r_sync2;
    logic r_rx_d1;     // rx_s delayed by one cycle

`ifdef UART_RX_MAJORITY_EN
    logic r_rx_d2;     // rx_s delayed by two cycles

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_d2 <= 1'b1;
        end else begin
            r_rx_d2 <= r_rx_d1;
        end
    end

    // Evaluated one cycle after the nominal mid-bit point, so the three
    // taps cover mid-1, mid and mid+1.
    assign bit_val = (r_sync2 & r_rx_d1) | (r_sync2 & r_rx_d2) | (r_rx_d1 & r_rx_d2);
`else
    assign bit_val = r_sync2;
`endif

    // Reset to the idle level so leaving reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_rx_d1 <= 1'b1;
        end else begin
            r_sync1 <= in_data;
            r_sync2 <= r_sync1;
            r_rx_d1 <= r_sync2;
        end
    end

    assign rx_s    = r_sync2;
    assign rx_fall = r_rx_d1 & ~r_sync2;

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_param
// Description : Parametrised UART receiver with configurable data width,
//               parity mode, stop-bit count and bit-period divider. Rejects
//               false starts, checks parity and stop bits, and presents each
//               word on a valid/ready interface with sticky overrun detection.
//               Build option UART_RX_MAJORITY_EN: 2-of-3 majority bit
//               decisions, all sample points one cycle later.
// Parameters  : CLK_DIV   - clk cycles per bit (>= 16)
//               DATA_BITS - data bits per frame (5..9)
//               PARITY    - 0 none, 1 odd, 2 even
//               STOP_BITS - 1 or 2
// Ports       : clk           - system clock
//               rst_n         - asynchronous active-low reset
//               in_data       - raw RX pin, idle high
//               o_data        - received word, LSB first on the line
//               o_valid       - o_data and error flags are valid
//               i_ready       - consumer accepts the word
//               o_parity_err  - parity mismatch for o_data
//               o_frame_err   - a stop bit was sampled low for o_data
//               o_overrun     - sticky, a word was overwritten unread
//               i_clr_overrun - clears o_overrun
//               busy          - frame reception in progress
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
    parameter int CLK_DIV   = 10416,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_data,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    input  logic                 i_clr_overrun,
    output logic                 busy
);

    import uart_pkg::*;

    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

`ifdef UART_RX_MAJORITY_EN
    localparam int c_SAMPLE_OFS = 1;
`else
    localparam int c_SAMPLE_OFS = 0;
`endif

    // Only the start-bit check carries the majority offset: the baud counter
    // restarts from that point, so every later sample inherits the shift.
    localparam logic [BAUD_W-1:0] c_HALF_CNT  = BAUD_W'(CLK_DIV / 2 - 1 + c_SAMPLE_OFS);
    localparam logic [BAUD_W-1:0] c_FULL_CNT  = BAUD_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  c_LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  c_LAST_STOP = BIT_W'(STOP_BITS - 1);

    logic w_rx_s;
    logic w_rx_fall;
    logic w_bit_val;

    rx_state_t            r_state;
    logic [BAUD_W-1:0]    r_baud_cnt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic                 r_frame_err;
    logic                 r_done;
    logic                 r_busy;

    uart_rx_sampler u_sampler (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_data (in_data),
        .rx_s    (w_rx_s),
        .rx_fall (w_rx_fall),
        .bit_val (w_bit_val)
    );

    // ------------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_baud_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A line held low after a break never produces a new
                    // edge, so the receiver waits here until it recovers.
                    if (w_rx_fall && !w_rx_s) begin
                        r_state    <= START;
                        r_baud_cnt <= '0;
                        r_busy     <= 1'b1;
                    end
                end

                START: begin
                    if (r_baud_cnt == c_HALF_CNT) begin
                        if (w_bit_val) begin
                            // Line is back high at mid start bit: glitch.
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state     <= DATA;
                            r_bit_cnt   <= '0;
                            r_baud_cnt  <= '0;
                            r_par_err   <= 1'b0;
                            r_frame_err <= 1'b0;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end

                DATA: begin
                    if (r_baud_cnt == c_FULL_CNT) begin
                        r_baud_cnt <= '0;
                        // Shifting in from the top leaves the first bit
                        // received at the LSB after DATA_BITS samples.
                        r_shift <= {w_bit_val, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == c_LAST_BIT) begin
                            r_bit_cnt <= '0;
                            r_state   <= (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end

                uart_pkg::PARITY: begin
                    if (r_baud_cnt == c_FULL_CNT) begin
                        r_baud_cnt <= '0;
                        r_par_err  <= parity_error(PARITY, (^r_shift) ^ w_bit_val);
                        r_state    <= STOP;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end

                STOP: begin
                    if (r_baud_cnt == c_FULL_CNT) begin
                        r_baud_cnt <= '0;
                        if (!w_bit_val) begin
                            r_frame_err <= 1'b1;
                        end
                        // Leave at the last mid-stop sample so the next start
                        // edge is caught even in back-to-back traffic.
                        if (r_bit_cnt == c_LAST_STOP) begin
                            r_bit_cnt <= '0;
                            r_state   <= IDLE;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end

                default: begin
                    r_state    <= IDLE;
                    r_baud_cnt <= '0;
                    r_bit_cnt  <= '0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output register and handshake
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            if (r_done) begin
                // A new word always wins over a handshake on the same cycle.
                o_data       <= r_shift;
                o_parity_err <= r_par_err;
                o_frame_err  <= r_frame_err;
                o_valid      <= 1'b1;
                if (o_valid && !i_ready) begin
                    o_overrun <= 1'b1;
                end else if (i_clr_overrun) begin
                    o_overrun <= 1'b0;
                end
            end else begin
                if (o_valid && i_ready) begin
                    o_valid <= 1'b0;
                end
                if (i_clr_overrun) begin
                    o_overrun <= 1'b0;
                end
            end
        end
    end

    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_param
// Description : Directed self-checking bench for uart_rx_param. Three
//               instances (8N1, 8E2, 7O2) at CLK_DIV=16 are driven bit by bit
//               from a single stimulus sequence; expected words and flags are
//               hand-computed constants. Spike rejection is exercised only
//               when UART_RX_MAJORITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

    localparam int c_DIV = 16;

    logic clk;
    logic rst_n;

    logic       rx_a, rdy_a, clr_a;
    logic [7:0] a_data;
    logic       a_valid, a_perr, a_ferr, a_ovr, a_busy;

    logic       rx_b, rdy_b, clr_b;
    logic [7:0] b_data;
    logic       b_valid, b_perr, b_ferr, b_ovr, b_busy;

    logic       rx_c, rdy_c, clr_c;
    logic [6:0] c_data;
    logic       c_valid, c_perr, c_ferr, c_ovr, c_busy;

    int checks = 0;
    int errors = 0;

    // Accepted-word capture (valid && ready) per instance
    int         a_acc = 0, b_acc = 0, c_acc = 0;
    int         a_vcyc = 0, a_busy_cyc = 0;
    logic [7:0] a_last = '0, b_last = '0;
    logic [6:0] c_last = '0;
    logic       a_perr_l = 1'b0, a_ferr_l = 1'b0;
    logic       b_perr_l = 1'b0, b_ferr_l = 1'b0;
    logic       c_perr_l = 1'b0, c_ferr_l = 1'b0;

    uart_rx_param #(.CLK_DIV(c_DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(rx_a), .o_data(a_data), .o_valid(a_valid),
        .i_ready(rdy_a), .o_parity_err(a_perr), .o_frame_err(a_ferr), .o_overrun(a_ovr),
        .i_clr_overrun(clr_a), .busy(a_busy)
    );

    uart_rx_param #(.CLK_DIV(c_DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(rx_b), .o_data(b_data), .o_valid(b_valid),
        .i_ready(rdy_b), .o_parity_err(b_perr), .o_frame_err(b_ferr), .o_overrun(b_ovr),
        .i_clr_overrun(clr_b), .busy(b_busy)
    );

    uart_rx_param #(.CLK_DIV(c_DIV), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_data(rx_c), .o_data(c_data), .o_valid(c_valid),
        .i_ready(rdy_c), .o_parity_err(c_perr), .o_frame_err(c_ferr), .o_overrun(c_ovr),
        .i_clr_overrun(clr_c), .busy(c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitors sample 2 time units after the active edge; stimulus changes
    // on the falling edge.
    always @(posedge clk) begin
        #2;
        if (a_valid) a_vcyc++;
        if (a_busy) a_busy_cyc++;
        if (a_valid && rdy_a) begin
            a_acc++; a_last = a_data; a_perr_l = a_perr; a_ferr_l = a_ferr;
        end
        if (b_valid && rdy_b) begin
            b_acc++; b_last = b_data; b_perr_l = b_perr; b_ferr_l = b_ferr;
        end
        if (c_valid && rdy_c) begin
            c_acc++; c_last = c_data; c_perr_l = c_perr; c_ferr_l = c_ferr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input int d, input logic v);
        case (d)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives bits[0..n-1] one bit period each; spike_bit >= 0 inverts that
    // bit for the single cycle at its mid-point.
    task automatic send(input int d, input logic [15:0] bits, input int n, input int spike_bit);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < c_DIV; c++) begin
                set_line(d, bits[i] ^ ((i == spike_bit) && (c == c_DIV / 2)));
                @(negedge clk);
            end
        end
        set_line(d, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
        rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b1;
        clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
        idle(3);

        // Reset state
        chk("rst_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_data", {24'd0, a_data}, 32'd0);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_ovr", {31'd0, a_ovr}, 32'd0);
        rst_n = 1'b1;
        idle(5);

        // 8N1 0xA5
        a_acc = 0; a_vcyc = 0; a_busy_cyc = 0;
        send(0, {1'b1, 8'hA5, 1'b0}, 10, -1);
        idle(20);
        chk("a5_count", a_acc, 32'd1);
        chk("a5_data", {24'd0, a_last}, 32'hA5);
        chk("a5_perr", {31'd0, a_perr_l}, 32'd0);
        chk("a5_ferr", {31'd0, a_ferr_l}, 32'd0);
        chk("a5_valid_cycles", a_vcyc, 32'd1);
        chk("a5_busy_len", {31'd0, (a_busy_cyc >= 150 && a_busy_cyc <= 156)}, 32'd1);

        // 8E2 0x37: five ones, even parity bit = 1
        send(1, {2'b11, 1'b1, 8'h37, 1'b0}, 12, -1);
        idle(20);
        chk("e_ok_count", b_acc, 32'd1);
        chk("e_ok_data", {24'd0, b_last}, 32'h37);
        chk("e_ok_perr", {31'd0, b_perr_l}, 32'd0);
        send(1, {2'b11, 1'b0, 8'h37, 1'b0}, 12, -1);
        idle(20);
        chk("e_bad_count", b_acc, 32'd2);
        chk("e_bad_data", {24'd0, b_last}, 32'h37);
        chk("e_bad_perr", {31'd0, b_perr_l}, 32'd1);
        // Second stop bit low
        send(1, {1'b0, 1'b1, 1'b1, 8'h37, 1'b0}, 12, -1);
        idle(20);
        chk("stop2_count", b_acc, 32'd3);
        chk("stop2_data", {24'd0, b_last}, 32'h37);
        chk("stop2_ferr", {31'd0, b_ferr_l}, 32'd1);
        chk("stop2_perr", {31'd0, b_perr_l}, 32'd0);

        // 4-cycle glitch while idle
        a_busy_cyc = 0;
        rx_a = 1'b0;
        idle(4);
        rx_a = 1'b1;
        idle(8);
        chk("glitch_busy_low", {31'd0, a_busy}, 32'd0);
        chk("glitch_busy_len", {31'd0, (a_busy_cyc >= 1 && a_busy_cyc <= 11)}, 32'd1);
        idle(20);
        chk("glitch_no_word", a_acc, 32'd1);
        chk("glitch_valid", {31'd0, a_valid}, 32'd0);

        // Overrun: two back-to-back words with no consumer
        rdy_a = 1'b0;
        send(0, {1'b1, 8'h11, 1'b0}, 10, -1);
        chk("ovr_first_valid", {31'd0, a_valid}, 32'd1);
        chk("ovr_first_data", {24'd0, a_data}, 32'h11);
        chk("ovr_first_flag", {31'd0, a_ovr}, 32'd0);
        send(0, {1'b1, 8'h22, 1'b0}, 10, -1);
        chk("ovr_second_valid", {31'd0, a_valid}, 32'd1);
        chk("ovr_second_data", {24'd0, a_data}, 32'h22);
        chk("ovr_set", {31'd0, a_ovr}, 32'd1);
        clr_a = 1'b1;
        idle(1);
        clr_a = 1'b0;
        chk("ovr_cleared", {31'd0, a_ovr}, 32'd0);
        chk("ovr_valid_held", {31'd0, a_valid}, 32'd1);
        rdy_a = 1'b1;
        idle(1);
        chk("hs_valid_drop", {31'd0, a_valid}, 32'd0);
        chk("hs_data_hold", {24'd0, a_data}, 32'h22);

        // Reset in the middle of the data bits
        send(0, {1'b1, 8'h5A, 1'b0}, 5, -1);
        rx_a = 1'b1;
        idle(3);
        chk("mid_busy", {31'd0, a_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_data", {24'd0, a_data}, 32'd0);
        chk("arst_busy", {31'd0, a_busy}, 32'd0);
        chk("arst_valid", {31'd0, a_valid}, 32'd0);
        idle(3);
        rst_n = 1'b1;
        idle(5);
        a_acc = 0;
        send(0, {1'b1, 8'h3C, 1'b0}, 10, -1);
        idle(20);
        chk("post_rst_count", a_acc, 32'd1);
        chk("post_rst_data", {24'd0, a_last}, 32'h3C);
        chk("post_rst_ferr", {31'd0, a_ferr_l}, 32'd0);

        // 7O2 0x7F: seven ones, odd parity bit = 0
        send(2, {2'b11, 1'b0, 7'h7F, 1'b0}, 11, -1);
        idle(20);
        chk("o7_count", c_acc, 32'd1);
        chk("o7_data", {25'd0, c_last}, 32'h7F);
        chk("o7_perr", {31'd0, c_perr_l}, 32'd0);
        chk("o7_ferr", {31'd0, c_ferr_l}, 32'd0);
        send(2, {2'b11, 1'b1, 7'h7F, 1'b0}, 11, -1);
        idle(20);
        chk("o7_bad_perr", {31'd0, c_perr_l}, 32'd1);
        chk("o7_bad_data", {25'd0, c_last}, 32'h7F);

`ifdef UART_RX_MAJORITY_EN
        // One-cycle low spike at the middle of data bit 2
        send(2, {2'b11, 1'b0, 7'h7F, 1'b0}, 11, 3);
        idle(20);
        chk("spike_count", c_acc, 32'd3);
        chk("spike_data", {25'd0, c_last}, 32'h7F);
        chk("spike_perr", {31'd0, c_perr_l}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

endmodule
`default_nettype wire
